riscv_dm_hart_ctrl: RTL and testbench
=====================================

# riscv_dm_hart_ctrl

Per-hart run-control sequencer between the Debug Module's hart control bus and one core's debug-mode pins. It turns halt, resume, program-buffer and reset requests into core commands and reports core state back as halted, running, parked, resume-ack, havereset and unavail. One instance per hart sits directly downstream of `riscv_dm_wrapper`'s hartctl bus.

## Interface
- `PB_TIMEOUT`, 1024: cycles allowed for one program-buffer run before abort; 0 disables the timeout.
- `RESET_CYCLES`, 16: minimum cycles `core_reset_o` is held.

Ports. One clock; reset is asynchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `halt_request_i` in 1: DM halt request (level).
- `resume_request_i` in 1: DM resume request (level).
- `progbuf_run_req_i` in 1: DM program-buffer run request (level).
- `halt_on_reset_i` in 1: halt after hart reset completes.
- `hart_reset_i` in 1: DM hart reset (level).
- `ackhavereset_i` in 1: pulse; clears `havereset_o`.
- `halted_o` out 1: hart halted (HALTED or PB_RUN).
- `running_o` out 1: hart running.
- `resume_ack_o` out 1: one-cycle resume acknowledge.
- `progbuf_run_ack_o` out 1: one-cycle program-buffer completion.
- `pb_error_o` out 1: one-cycle pulse, coincident with the ack, on exception or timeout.
- `parked_o` out 1: hart idle in park loop (HALTED only).
- `havereset_o` out 1: sticky reset-seen flag.
- `unavail_o` out 1: hart in reset.
- `core_halt_req_o` out 1: level request to enter debug mode.
- `core_halted_i` in 1: core in debug mode.
- `core_resume_o` out 1: one-cycle pulse, return to dpc.
- `core_pb_start_o` out 1: one-cycle pulse, jump to progbuf base.
- `core_pb_done_i` in 1: pulse, ebreak executed in debug mode.
- `core_pb_exception_i` in 1: pulse, exception in debug mode.
- `core_reset_o` out 1: core reset.
- `core_reset_done_i` in 1: core out of reset.

## Operation
- States: RESET, RUNNING, HALTING, HALTED, PB_RUN, RESUMING.
- Priority when requests coincide: `hart_reset_i` > halt > progbuf > resume.
- Rearm latch: after acking a resume or program-buffer request, the block ignores that request until it is seen low for at least one cycle.
- RESET:
  - `core_reset_o`=1, `unavail_o`=1.
  - Leaves when `hart_reset_i`=0, the cycle counter ≥ `RESET_CYCLES` and `core_reset_done_i`=1.
  - On exit, `havereset_o` sets. Next state is HALTING if `halt_on_reset_i`, else RUNNING.
- RUNNING:
  - `running_o`=1.
  - `halt_request_i` → HALTING.
- HALTING:
  - `core_halt_req_o`=1.
  - `core_halted_i` → HALTED.
- HALTED:
  - `halted_o`=1, `parked_o`=1.
  - Armed `progbuf_run_req_i` → PB_RUN; pulses `core_pb_start_o` on the transition cycle and clears the timeout counter.
  - Armed `resume_request_i` (with no halt request) → RESUMING; pulses `core_resume_o`.
- PB_RUN:
  - `halted_o`=1, `parked_o`=0, timeout counter increments.
  - `core_pb_done_i` → HALTED, pulses `progbuf_run_ack_o`.
  - `core_pb_exception_i`, or counter = `PB_TIMEOUT`−1 with `PB_TIMEOUT`≠0 → HALTED, pulses `progbuf_run_ack_o` and `pb_error_o`.
  - Done and exception in the same cycle: treated as an exception.
- RESUMING:
  - Waits for `core_halted_i`=0 → RUNNING, pulses `resume_ack_o`.
  - A halt request arriving here is taken once RUNNING is reached.
- `hart_reset_i`=1 in any state → RESET next cycle and restarts the reset counter. No ack is issued for an interrupted program-buffer run or resume.
- `havereset_o`: set wins over a simultaneous `ackhavereset_i`.
- Saturation: the reset counter saturates at `RESET_CYCLES`; the timeout counter is `$clog2(PB_TIMEOUT+1)` bits.

## Timing
- Reset values:
  - State RESET, `core_reset_o`=1, `unavail_o`=1, `havereset_o`=0.
  - All other outputs 0; counters 0; rearm latches armed.
- All outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- Latencies:
  - Halt request → `core_halt_req_o` after 1 cycle; `core_halted_i` → `halted_o` after 1 cycle.
  - Progbuf request → `core_pb_start_o` pulse after 1 cycle; `core_pb_done_i` → `progbuf_run_ack_o` after 1 cycle.
  - Shortest reset: `RESET_CYCLES`+1 cycles after `hart_reset_i` falls, given `core_reset_done_i` is already high.

## Structure
- `riscv_dm_pkg` gains the `hart_ctrl_state_e` enum; widths stay local.
- One natural sub-module: `riscv_dm_req_rearm`, an edge-rearm latch instantiated for resume and for progbuf.

## Test plan
- Reset release with `halt_on_reset_i`=0, `RESET_CYCLES`=16, `core_reset_done_i` tied 1 → `running_o` rises 17 cycles after `hart_reset_i` falls, `havereset_o`=1; a pulse on `ackhavereset_i` clears it.
- Halt then resume → `core_halt_req_o` rises, `halted_o`/`parked_o` follow `core_halted_i` by 1 cycle. Resume gives one `core_resume_o` pulse and one `resume_ack_o` pulse; holding the request high gives no second ack.
- Progbuf success: `core_pb_done_i` 5 cycles after start → `progbuf_run_ack_o` pulses once, `pb_error_o`=0, `parked_o` returns to 1.
- Progbuf exception and timeout (`PB_TIMEOUT`=8, no done) → ack plus `pb_error_o` on cycle 8 after start; done and exception in the same cycle gives an error.
- `hart_reset_i` asserted mid PB_RUN → RESET next cycle, no ack, `unavail_o`=1. With `halt_on_reset_i`=1, the block ends in HALTED and `havereset_o`=1.
- Simultaneous halt and resume while RUNNING → halt is taken and `resume_ack_o` stays 0. Set vs ack on `havereset_o` in the same cycle → stays 1.

Source files
------------

// File: rtl/riscv_dm_pkg.sv
// Shared Debug Module types.
// The hart run-control states are kept here so other DM blocks can decode them.
package riscv_dm_pkg;

  typedef enum logic [2:0] {
    HC_RESET    = 3'd0,
    HC_RUNNING  = 3'd1,
    HC_HALTING  = 3'd2,
    HC_HALTED   = 3'd3,
    HC_PB_RUN   = 3'd4,
    HC_RESUMING = 3'd5
  } hart_ctrl_state_e;

endpackage

// File: rtl/riscv_dm_hart_ctrl_if.sv
// Per-hart control bus from the Debug Module plus the core's debug-mode pins.
// Directions are named from the sequencer's side (slave).
interface riscv_dm_hart_ctrl_if;
  logic halt_request_i;
  logic resume_request_i;
  logic progbuf_run_req_i;
  logic halt_on_reset_i;
  logic hart_reset_i;
  logic ackhavereset_i;
  logic halted_o;
  logic running_o;
  logic resume_ack_o;
  logic progbuf_run_ack_o;
  logic pb_error_o;
  logic parked_o;
  logic havereset_o;
  logic unavail_o;
  logic core_halt_req_o;
  logic core_halted_i;
  logic core_resume_o;
  logic core_pb_start_o;
  logic core_pb_done_i;
  logic core_pb_exception_i;
  logic core_reset_o;
  logic core_reset_done_i;

  modport slave (
    input  halt_request_i, resume_request_i, progbuf_run_req_i, halt_on_reset_i,
           hart_reset_i, ackhavereset_i, core_halted_i, core_pb_done_i,
           core_pb_exception_i, core_reset_done_i,
    output halted_o, running_o, resume_ack_o, progbuf_run_ack_o, pb_error_o,
           parked_o, havereset_o, unavail_o, core_halt_req_o, core_resume_o,
           core_pb_start_o, core_reset_o
  );

  modport master (
    output halt_request_i, resume_request_i, progbuf_run_req_i, halt_on_reset_i,
           hart_reset_i, ackhavereset_i, core_halted_i, core_pb_done_i,
           core_pb_exception_i, core_reset_done_i,
    input  halted_o, running_o, resume_ack_o, progbuf_run_ack_o, pb_error_o,
           parked_o, havereset_o, unavail_o, core_halt_req_o, core_resume_o,
           core_pb_start_o, core_reset_o
  );
endinterface

// File: rtl/riscv_dm_req_rearm.sv
// Edge-rearm latch: once a level request has been taken it is masked
// until the requester drops it for at least one cycle.
module riscv_dm_req_rearm (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic take_i,
  output logic armed_o
);

  logic armed_d, armed_q;

  always_comb begin
    armed_d = armed_q;
    if (take_i) begin
      armed_d = 1'b0;
    end else if (!req_i) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign armed_o = armed_q;

endmodule

// File: rtl/riscv_dm_hart_ctrl.sv
// Per-hart run-control sequencer: maps DM halt/resume/progbuf/reset requests
// onto core debug-mode commands and reports hart status back to the DM.
module riscv_dm_hart_ctrl
  import riscv_dm_pkg::*;
#(
  parameter int unsigned PB_TIMEOUT   = 1024,
  parameter int unsigned RESET_CYCLES = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  riscv_dm_hart_ctrl_if.slave hc
);

  localparam int unsigned RC_W = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam int unsigned TO_W = (PB_TIMEOUT > 0) ? $clog2(PB_TIMEOUT + 1) : 1;
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(RESET_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = (PB_TIMEOUT == 0) ? '0 : TO_W'(PB_TIMEOUT - 1);
  localparam bit              TO_EN   = (PB_TIMEOUT != 0);

  hart_ctrl_state_e state_d, state_q;
  logic [RC_W-1:0]  rcnt_d, rcnt_q;
  logic [TO_W-1:0]  tcnt_d, tcnt_q;
  logic havereset_d, havereset_q;
  logic resume_ack_d, resume_ack_q;
  logic pb_ack_d, pb_ack_q;
  logic pb_err_d, pb_err_q;
  logic core_resume_d, core_resume_q;
  logic core_pb_start_d, core_pb_start_q;
  logic take_res_s, take_pb_s, res_armed_s, pb_armed_s, hr_set_s;

  riscv_dm_req_rearm u_rearm_resume (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (hc.resume_request_i),
    .take_i (take_res_s),
    .armed_o(res_armed_s)
  );

  riscv_dm_req_rearm u_rearm_progbuf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (hc.progbuf_run_req_i),
    .take_i (take_pb_s),
    .armed_o(pb_armed_s)
  );

  always_comb begin
    state_d         = state_q;
    rcnt_d          = rcnt_q;
    tcnt_d          = tcnt_q;
    resume_ack_d    = 1'b0;
    pb_ack_d        = 1'b0;
    pb_err_d        = 1'b0;
    core_resume_d   = 1'b0;
    core_pb_start_d = 1'b0;
    take_res_s      = 1'b0;
    take_pb_s       = 1'b0;
    hr_set_s        = 1'b0;
    // Hart reset pre-empts every state and silently drops in-flight acks.
    if (hc.hart_reset_i) begin
      state_d = HC_RESET;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        HC_RESET: begin
          if (rcnt_q != RC_MAX) begin
            rcnt_d = rcnt_q + RC_W'(1);
          end else begin
            rcnt_d = rcnt_q;
          end
          if ((rcnt_q >= RC_MAX) && hc.core_reset_done_i) begin
            hr_set_s = 1'b1;
            state_d  = hc.halt_on_reset_i ? HC_HALTING : HC_RUNNING;
          end else begin
            state_d = HC_RESET;
          end
        end
        HC_RUNNING: begin
          state_d = hc.halt_request_i ? HC_HALTING : HC_RUNNING;
        end
        HC_HALTING: begin
          state_d = hc.core_halted_i ? HC_HALTED : HC_HALTING;
        end
        HC_HALTED: begin
          if (hc.progbuf_run_req_i && pb_armed_s) begin
            state_d         = HC_PB_RUN;
            core_pb_start_d = 1'b1;
            tcnt_d          = '0;
            take_pb_s       = 1'b1;
          end else if (hc.resume_request_i && res_armed_s && !hc.halt_request_i) begin
            state_d       = HC_RESUMING;
            core_resume_d = 1'b1;
            take_res_s    = 1'b1;
          end else begin
            state_d = HC_HALTED;
          end
        end
        HC_PB_RUN: begin
          if (tcnt_q != {TO_W{1'b1}}) begin
            tcnt_d = tcnt_q + TO_W'(1);
          end else begin
            tcnt_d = tcnt_q;
          end
          if (hc.core_pb_exception_i || (TO_EN && (tcnt_q == TO_LAST))) begin
            state_d  = HC_HALTED;
            pb_ack_d = 1'b1;
            pb_err_d = 1'b1;
          end else if (hc.core_pb_done_i) begin
            state_d  = HC_HALTED;
            pb_ack_d = 1'b1;
          end else begin
            state_d = HC_PB_RUN;
          end
        end
        HC_RESUMING: begin
          if (!hc.core_halted_i) begin
            state_d      = HC_RUNNING;
            resume_ack_d = 1'b1;
          end else begin
            state_d = HC_RESUMING;
          end
        end
        default: begin
          state_d = HC_RESET;
          rcnt_d  = '0;
        end
      endcase
    end
    if (hr_set_s) begin
      havereset_d = 1'b1;
    end else if (hc.ackhavereset_i) begin
      havereset_d = 1'b0;
    end else begin
      havereset_d = havereset_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= HC_RESET;
      rcnt_q          <= '0;
      tcnt_q          <= '0;
      havereset_q     <= 1'b0;
      resume_ack_q    <= 1'b0;
      pb_ack_q        <= 1'b0;
      pb_err_q        <= 1'b0;
      core_resume_q   <= 1'b0;
      core_pb_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rcnt_q          <= rcnt_d;
      tcnt_q          <= tcnt_d;
      havereset_q     <= havereset_d;
      resume_ack_q    <= resume_ack_d;
      pb_ack_q        <= pb_ack_d;
      pb_err_q        <= pb_err_d;
      core_resume_q   <= core_resume_d;
      core_pb_start_q <= core_pb_start_d;
    end
  end

  assign hc.halted_o          = (state_q == HC_HALTED) || (state_q == HC_PB_RUN);
  assign hc.parked_o          = (state_q == HC_HALTED);
  assign hc.running_o         = (state_q == HC_RUNNING);
  assign hc.core_halt_req_o   = (state_q == HC_HALTING);
  assign hc.core_reset_o      = (state_q == HC_RESET);
  assign hc.unavail_o         = (state_q == HC_RESET);
  assign hc.havereset_o       = havereset_q;
  assign hc.resume_ack_o      = resume_ack_q;
  assign hc.progbuf_run_ack_o = pb_ack_q;
  assign hc.pb_error_o        = pb_err_q;
  assign hc.core_resume_o     = core_resume_q;
  assign hc.core_pb_start_o   = core_pb_start_q;

endmodule

// File: tb/tb_riscv_dm_hart_ctrl.sv
// Bench for riscv_dm_hart_ctrl: directed run-control scenarios followed by
// random traffic, all compared every cycle against a behavioural hart model.
module tb_riscv_dm_hart_ctrl;

  localparam int PB_TO  = 8;
  localparam int RST_CY = 16;
  localparam int S_RESET = 0, S_RUN = 1, S_HALTING = 2, S_HALTED = 3, S_PB = 4, S_RESUMING = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_dm_hart_ctrl_if hc ();

  riscv_dm_hart_ctrl #(.PB_TIMEOUT(PB_TO), .RESET_CYCLES(RST_CY)) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .hc   (hc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_rack   = 0;
  int n_pback  = 0;

  // behavioural model of the hart as seen from the DM
  int m_st;
  int m_rcnt;
  int m_pbc;
  bit m_havereset, m_res_armed, m_pb_armed;
  bit m_rack, m_pback, m_perr, m_cres, m_cpbs;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_RESET; m_rcnt = 0; m_pbc = 0;
    m_havereset = 1'b0; m_res_armed = 1'b1; m_pb_armed = 1'b1;
    m_rack = 1'b0; m_pback = 1'b0; m_perr = 1'b0; m_cres = 1'b0; m_cpbs = 1'b0;
  endtask

  task automatic model_tick();
    bit took_res, took_pb, set_hr;
    took_res = 1'b0; took_pb = 1'b0; set_hr = 1'b0;
    m_rack = 1'b0; m_pback = 1'b0; m_perr = 1'b0; m_cres = 1'b0; m_cpbs = 1'b0;
    if (hc.hart_reset_i) begin
      m_st = S_RESET;
      m_rcnt = 0;
    end else begin
      case (m_st)
        S_RESET: begin
          m_rcnt++;
          if (m_rcnt > RST_CY && hc.core_reset_done_i) begin
            set_hr = 1'b1;
            m_st = hc.halt_on_reset_i ? S_HALTING : S_RUN;
          end
        end
        S_RUN:     if (hc.halt_request_i) m_st = S_HALTING;
        S_HALTING: if (hc.core_halted_i) m_st = S_HALTED;
        S_HALTED: begin
          if (hc.progbuf_run_req_i && m_pb_armed) begin
            m_st = S_PB; m_cpbs = 1'b1; m_pbc = 0; took_pb = 1'b1;
          end else if (hc.resume_request_i && m_res_armed && !hc.halt_request_i) begin
            m_st = S_RESUMING; m_cres = 1'b1; took_res = 1'b1;
          end
        end
        S_PB: begin
          m_pbc++;
          if (hc.core_pb_exception_i || m_pbc == PB_TO) begin
            m_st = S_HALTED; m_pback = 1'b1; m_perr = 1'b1;
          end else if (hc.core_pb_done_i) begin
            m_st = S_HALTED; m_pback = 1'b1;
          end
        end
        S_RESUMING: if (!hc.core_halted_i) begin
          m_st = S_RUN; m_rack = 1'b1;
        end
        default: m_st = S_RESET;
      endcase
    end
    if (set_hr) m_havereset = 1'b1;
    else if (hc.ackhavereset_i) m_havereset = 1'b0;
    m_res_armed = took_res ? 1'b0 : (!hc.resume_request_i ? 1'b1 : m_res_armed);
    m_pb_armed  = took_pb  ? 1'b0 : (!hc.progbuf_run_req_i ? 1'b1 : m_pb_armed);
  endtask

  task automatic check_outputs();
    chk("halted",       hc.halted_o,          int'(m_st == S_HALTED || m_st == S_PB));
    chk("parked",       hc.parked_o,          int'(m_st == S_HALTED));
    chk("running",      hc.running_o,         int'(m_st == S_RUN));
    chk("unavail",      hc.unavail_o,         int'(m_st == S_RESET));
    chk("core_reset",   hc.core_reset_o,      int'(m_st == S_RESET));
    chk("core_halt_req", hc.core_halt_req_o,  int'(m_st == S_HALTING));
    chk("havereset",    hc.havereset_o,       int'(m_havereset));
    chk("resume_ack",   hc.resume_ack_o,      int'(m_rack));
    chk("pb_ack",       hc.progbuf_run_ack_o, int'(m_pback));
    chk("pb_error",     hc.pb_error_o,        int'(m_perr));
    chk("core_resume",  hc.core_resume_o,     int'(m_cres));
    chk("core_pb_start", hc.core_pb_start_o,  int'(m_cpbs));
    if (hc.resume_ack_o) n_rack++;
    if (hc.progbuf_run_ack_o) n_pback++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_tick();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    hc.halt_request_i = 1'b0; hc.resume_request_i = 1'b0; hc.progbuf_run_req_i = 1'b0;
    hc.halt_on_reset_i = 1'b0; hc.hart_reset_i = 1'b1; hc.ackhavereset_i = 1'b1;
    hc.core_halted_i = 1'b0; hc.core_pb_done_i = 1'b0; hc.core_pb_exception_i = 1'b0;
    hc.core_reset_done_i = 1'b1;
    model_reset();
    #2;
    chk("rst_core_reset", hc.core_reset_o, 1);
    chk("rst_havereset", hc.havereset_o, 0);
    run(3);
    rst = 1'b0;
    run(3);

    // reset release latency, with ack held so the set/ack collision is exercised
    hc.hart_reset_i = 1'b0;
    n = 0;
    while (!hc.running_o && n < 40) begin step(); n++; end
    chk("rst_release_latency", n, RST_CY + 1);
    chk("havereset_set_beats_ack", hc.havereset_o, 1);
    hc.ackhavereset_i = 1'b0;
    run(2);
    hc.ackhavereset_i = 1'b1; step(); hc.ackhavereset_i = 1'b0;
    chk("havereset_cleared", hc.havereset_o, 0);

    // simultaneous halt and resume while running: halt wins, no resume ack
    base = n_rack;
    hc.halt_request_i = 1'b1; hc.resume_request_i = 1'b1;
    step();
    chk("halt_req_latency", hc.core_halt_req_o, 1);
    hc.core_halted_i = 1'b1;
    step();
    chk("halted_latency", hc.parked_o, 1);
    run(3);
    chk("halt_vs_resume_no_ack", n_rack - base, 0);
    hc.resume_request_i = 1'b0; hc.halt_request_i = 1'b0;
    step();

    // progbuf success: done 5 cycles after start
    base = n_pback;
    hc.progbuf_run_req_i = 1'b1; step();
    chk("pb_start", hc.core_pb_start_o, 1);
    run(4);
    hc.core_pb_done_i = 1'b1; step(); hc.core_pb_done_i = 1'b0;
    chk("pb_ok_ack", hc.progbuf_run_ack_o, 1);
    chk("pb_ok_noerr", hc.pb_error_o, 0);
    run(4);
    chk("pb_ok_single_ack", n_pback - base, 1);
    hc.progbuf_run_req_i = 1'b0; step();

    // progbuf exception, then done+exception together
    hc.progbuf_run_req_i = 1'b1; run(2);
    hc.core_pb_exception_i = 1'b1; step(); hc.core_pb_exception_i = 1'b0;
    chk("pb_exc_err", hc.pb_error_o, 1);
    hc.progbuf_run_req_i = 1'b0; step();
    hc.progbuf_run_req_i = 1'b1; step();
    hc.core_pb_done_i = 1'b1; hc.core_pb_exception_i = 1'b1; step();
    hc.core_pb_done_i = 1'b0; hc.core_pb_exception_i = 1'b0;
    chk("pb_done_exc_err", hc.pb_error_o, 1);
    hc.progbuf_run_req_i = 1'b0; step();

    // progbuf timeout
    hc.progbuf_run_req_i = 1'b1; step();
    n = 0;
    while (!hc.progbuf_run_ack_o && n < 40) begin step(); n++; end
    chk("pb_timeout_cycle", n, PB_TO);
    chk("pb_timeout_err", hc.pb_error_o, 1);
    hc.progbuf_run_req_i = 1'b0; step();

    // resume: exactly one ack while the request is held
    base = n_rack;
    hc.resume_request_i = 1'b1; step();
    chk("core_resume_pulse", hc.core_resume_o, 1);
    hc.core_halted_i = 1'b0;
    run(10);
    chk("resume_ack_once", n_rack - base, 1);
    hc.resume_request_i = 1'b0;

    // hart reset mid progbuf, halt-on-reset
    hc.halt_request_i = 1'b1; step();
    hc.core_halted_i = 1'b1; step();
    hc.halt_request_i = 1'b0; hc.progbuf_run_req_i = 1'b1; run(2);
    base = n_pback;
    hc.halt_on_reset_i = 1'b1; hc.hart_reset_i = 1'b1; step();
    chk("mid_pb_unavail", hc.unavail_o, 1);
    hc.hart_reset_i = 1'b0; hc.progbuf_run_req_i = 1'b0;
    n = 0;
    while (!hc.parked_o && n < 60) begin step(); n++; end
    chk("hor_parked", hc.parked_o, 1);
    chk("hor_havereset", hc.havereset_o, 1);
    chk("mid_pb_no_ack", n_pback - base, 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) hc.halt_request_i    = ~hc.halt_request_i;
      if ($urandom_range(5) == 0) hc.resume_request_i  = ~hc.resume_request_i;
      if ($urandom_range(5) == 0) hc.progbuf_run_req_i = ~hc.progbuf_run_req_i;
      if ($urandom_range(31) == 0) hc.halt_on_reset_i  = ~hc.halt_on_reset_i;
      hc.hart_reset_i        = ($urandom_range(249) == 0);
      hc.ackhavereset_i      = ($urandom_range(15) == 0);
      hc.core_pb_done_i      = ($urandom_range(5) == 0);
      hc.core_pb_exception_i = ($urandom_range(13) == 0);
      hc.core_reset_done_i   = ($urandom_range(3) != 0);
      if (m_st == S_HALTING || m_st == S_HALTED || m_st == S_PB)
        hc.core_halted_i = ($urandom_range(5) != 0);
      else
        hc.core_halted_i = ($urandom_range(5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
